// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: widths, branch func3 codes
// and result-select encodings.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

endpackage

// File: rtl/branch_cond.sv
// Combinational branch comparator; flags the reserved func3 codes
// 010/011 as invalid and never takes them.
module branch_cond
    import riscv_pkg::*;
#(
    parameter int W = XLEN
) (
    input  logic [2:0]   func3,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         taken,
    output logic         valid_f3
);

    logic eq;
    logic lt;
    logic ltu;

    assign eq  = (a == b);
    assign lt  = ($signed(a) < $signed(b));
    assign ltu = (a < b);

    always_comb begin
        taken    = 1'b0;
        valid_f3 = 1'b1;
        unique case (1'b1)
            (func3 == F3_BEQ):  taken = eq;
            (func3 == F3_BNE):  taken = ~eq;
            (func3 == F3_BLT):  taken = lt;
            (func3 == F3_BGE):  taken = ~lt;
            (func3 == F3_BLTU): taken = ltu;
            (func3 == F3_BGEU): taken = ~ltu;
            default:            valid_f3 = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_ex_mem.sv
// EX-stage branch/jump resolution with same-cycle redirect, the EX/MEM
// pipeline register, a saturating redirect counter and a sticky flag.
module branch_resolve_ex_mem
    import riscv_pkg::*;
#(
    parameter int XLEN  = riscv_pkg::XLEN,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic             regwritee_i,
    input  logic [1:0]       resultsrce_i,
    input  logic             memwritee_i,
    input  logic             jumpe_i,
    input  logic             branche_i,
    input  logic [2:0]       func3e_i,
    input  logic [XLEN-1:0]  rs1_fwd_i,
    input  logic [XLEN-1:0]  rs2_fwd_i,
    input  logic [XLEN-1:0]  aluresulte_i,
    input  logic [4:0]       rde_i,
    input  logic [XLEN-1:0]  pcplus4e_i,
    output logic             pcsrce_o,
    output logic             flushd_o,
    output logic             flushe_o,
    output logic             regwritem_o,
    output logic [1:0]       resultsrcm_o,
    output logic             memwritem_o,
    output logic [2:0]       func3m_o,
    output logic [XLEN-1:0]  aluresultm_o,
    output logic [XLEN-1:0]  writedatam_o,
    output logic [4:0]       rdm_o,
    output logic [XLEN-1:0]  pcplus4m_o,
    output logic [CNT_W-1:0] redirect_cnt_o,
    output logic             illegal_branch_o
);

    logic cond;
    logic valid_f3;
    logic taken;

    branch_cond #(.W(XLEN)) u_cond (
        .func3    (func3e_i),
        .a        (rs1_fwd_i),
        .b        (rs2_fwd_i),
        .taken    (cond),
        .valid_f3 (valid_f3)
    );

    // A stalled branch stays in EX, so it redirects once stall drops.
    assign taken    = jumpe_i | (branche_i & cond);
    assign pcsrce_o = taken & ~stall_i;
    assign flushd_o = pcsrce_o;
    assign flushe_o = pcsrce_o;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            regwritem_o  <= 1'b0;
            resultsrcm_o <= RES_ALU;
            memwritem_o  <= 1'b0;
            func3m_o     <= 3'b000;
            aluresultm_o <= '0;
            writedatam_o <= '0;
            rdm_o        <= 5'd0;
            pcplus4m_o   <= '0;
        end else if (stall_i) begin
            regwritem_o  <= regwritem_o;
        end else if (flush_i) begin
            regwritem_o  <= 1'b0;
            resultsrcm_o <= RES_ALU;
            memwritem_o  <= 1'b0;
            func3m_o     <= 3'b000;
            aluresultm_o <= '0;
            writedatam_o <= '0;
            rdm_o        <= 5'd0;
            pcplus4m_o   <= '0;
        end else begin
            regwritem_o  <= regwritee_i;
            resultsrcm_o <= resultsrce_i;
            memwritem_o  <= memwritee_i;
            func3m_o     <= func3e_i;
            aluresultm_o <= aluresulte_i;
            writedatam_o <= rs2_fwd_i;
            rdm_o        <= rde_i;
            pcplus4m_o   <= pcplus4e_i;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            redirect_cnt_o <= '0;
        end else if (pcsrce_o && (redirect_cnt_o != '1)) begin
            redirect_cnt_o <= redirect_cnt_o + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            illegal_branch_o <= 1'b0;
        end else if (branche_i && !valid_f3 && !stall_i) begin
            illegal_branch_o <= 1'b1;
        end
    end

endmodule
